// File: rtl/mem_sched.sv
// mem_sched: round-robin arbiter putting icache reads and dcache reads/writebacks
// onto one 64-bit burst memory port, reassembling returned bursts per requester.
module mem_sched #(
    parameter int unsigned BURST_LEN = 4,
    parameter int unsigned LINE_W    = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       i_addr,
    input  logic              i_read,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic [31:0]       d_addr,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic [31:0]       bmem_addr,
    output logic              bmem_read,
    output logic              bmem_write,
    output logic [63:0]       bmem_wdata,
    input  logic              bmem_ready,
    input  logic [31:0]       bmem_raddr,
    input  logic [63:0]       bmem_rdata,
    input  logic              bmem_rvalid
);
    localparam int unsigned BEAT_W = 64;
    localparam int unsigned CNT_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    typedef enum logic {IDLE, WRITE} state_t;
    typedef enum logic {GNT_I, GNT_D} grant_t;

    state_t             state;
    grant_t             last_grant;
    logic [CNT_W-1:0]   wr_cnt;
    logic [CNT_W-1:0]   i_cnt;
    logic [CNT_W-1:0]   d_cnt;
    logic               i_out;
    logic               d_out;
    logic               d_out_rd;
    logic [26:0]        i_line;
    logic [26:0]        d_line;
    logic [LINE_W-1:0]  i_line_buf;
    logic [LINE_W-1:0]  d_line_buf;
    logic [LINE_W-1:0]  i_fill;
    logic [LINE_W-1:0]  d_fill;

    logic [26:0] i_req_line;
    logic [26:0] d_req_line;
    logic [26:0] ret_line;
    logic        i_elig;
    logic        d_elig;
    logic        gnt_i;
    logic        gnt_d;
    logic        i_hit;
    logic        d_hit;
    logic        unused_bits;

    assign i_req_line  = i_addr[31:5];
    assign d_req_line  = d_addr[31:5];
    assign ret_line    = bmem_raddr[31:5];
    assign unused_bits = ^{i_addr[4:0], d_addr[4:0], bmem_raddr[4:0]};

    // A requester is also held while its resp pulses, since it only drops its request after seeing it.
    // Same-line reads are serialised so a returning burst can never match both requesters.
    assign i_elig = (state == IDLE) && i_read && !i_out && !i_resp && bmem_ready
                    && !(d_out && d_out_rd && (d_line == i_req_line));
    assign d_elig = (state == IDLE) && (d_read || d_write) && !d_out && !d_resp && bmem_ready
                    && !(i_out && (i_line == d_req_line));

    assign gnt_i = i_elig && (!d_elig || (last_grant == GNT_D));
    assign gnt_d = d_elig && !gnt_i;

    assign i_hit = bmem_rvalid && i_out && (i_line == ret_line);
    assign d_hit = bmem_rvalid && d_out && d_out_rd && (d_line == ret_line) && !i_hit;

    always_comb begin
        i_fill = i_line_buf;
        d_fill = d_line_buf;
        i_fill[int'(i_cnt) * BEAT_W +: BEAT_W] = bmem_rdata;
        d_fill[int'(d_cnt) * BEAT_W +: BEAT_W] = bmem_rdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            last_grant <= GNT_I;
            wr_cnt     <= '0;
            i_cnt      <= '0;
            d_cnt      <= '0;
            i_out      <= 1'b0;
            d_out      <= 1'b0;
            d_out_rd   <= 1'b0;
            i_line     <= '0;
            d_line     <= '0;
            i_line_buf <= '0;
            d_line_buf <= '0;
            i_rdata    <= '0;
            d_rdata    <= '0;
            i_resp     <= 1'b0;
            d_resp     <= 1'b0;
            bmem_addr  <= '0;
            bmem_read  <= 1'b0;
            bmem_write <= 1'b0;
            bmem_wdata <= '0;
        end else begin
            bmem_read <= 1'b0;
            i_resp    <= 1'b0;
            d_resp    <= 1'b0;

            case (state)
                IDLE: begin
                    bmem_addr  <= '0;
                    bmem_write <= 1'b0;
                    bmem_wdata <= '0;
                    wr_cnt     <= '0;
                    if (gnt_i) begin
                        last_grant <= GNT_I;
                        i_out      <= 1'b1;
                        i_line     <= i_req_line;
                        bmem_read  <= 1'b1;
                        bmem_addr  <= {i_req_line, 5'b0};
                    end else if (gnt_d) begin
                        last_grant <= GNT_D;
                        d_out      <= 1'b1;
                        d_line     <= d_req_line;
                        bmem_addr  <= {d_req_line, 5'b0};
                        if (d_write) begin
                            state      <= WRITE;
                            d_out_rd   <= 1'b0;
                            bmem_write <= 1'b1;
                            bmem_wdata <= d_wdata[BEAT_W-1:0];
                        end else begin
                            d_out_rd  <= 1'b1;
                            bmem_read <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (wr_cnt == LAST_BEAT) begin
                        state      <= IDLE;
                        wr_cnt     <= '0;
                        d_out      <= 1'b0;
                        d_resp     <= 1'b1;
                        bmem_addr  <= '0;
                        bmem_write <= 1'b0;
                        bmem_wdata <= '0;
                    end else begin
                        wr_cnt     <= wr_cnt + 1'b1;
                        bmem_wdata <= d_wdata[(int'(wr_cnt) + 1) * BEAT_W +: BEAT_W];
                    end
                end
            endcase

            // Returning beats are steered by line tag, independently of the command FSM.
            if (i_hit) begin
                i_line_buf <= i_fill;
                if (i_cnt == LAST_BEAT) begin
                    i_cnt   <= '0;
                    i_out   <= 1'b0;
                    i_resp  <= 1'b1;
                    i_rdata <= i_fill;
                end else begin
                    i_cnt <= i_cnt + 1'b1;
                end
            end
            if (d_hit) begin
                d_line_buf <= d_fill;
                if (d_cnt == LAST_BEAT) begin
                    d_cnt   <= '0;
                    d_out   <= 1'b0;
                    d_resp  <= 1'b1;
                    d_rdata <= d_fill;
                end else begin
                    d_cnt <= d_cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_sched.sv
// Bench for mem_sched: scenario tasks push expected commands/responses to queues;
// a negedge monitor pops and compares them as the DUT produces them.
module tb_mem_sched;
    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  i_addr;
    logic         i_read;
    logic [255:0] i_rdata;
    logic         i_resp;
    logic [31:0]  d_addr;
    logic         d_read;
    logic         d_write;
    logic [255:0] d_wdata;
    logic [255:0] d_rdata;
    logic         d_resp;
    logic [31:0]  bmem_addr;
    logic         bmem_read;
    logic         bmem_write;
    logic [63:0]  bmem_wdata;
    logic         bmem_ready;
    logic [31:0]  bmem_raddr;
    logic [63:0]  bmem_rdata;
    logic         bmem_rvalid;

    typedef struct packed {
        logic        rd;
        logic [31:0] addr;
        logic [63:0] wdata;
    } cmd_t;
    typedef struct packed {
        logic         wr;
        logic [255:0] data;
    } resp_t;

    cmd_t         cmd_q[$];
    resp_t        i_q[$];
    resp_t        d_q[$];
    logic [255:0] i_last;
    logic [255:0] d_last;
    int           checks;
    int           errors;

    mem_sched #(.BURST_LEN(4), .LINE_W(256)) dut (
        .clk(clk), .rst(rst),
        .i_addr(i_addr), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
        .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
        .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] mk_line(input logic [31:0] seed);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[k*32 +: 32] = seed + 32'(k) * 32'h0101_0101;
        return l;
    endfunction

    task automatic push_rd(input logic [31:0] addr);
        cmd_t c;
        c.rd = 1'b1; c.addr = addr; c.wdata = '0;
        cmd_q.push_back(c);
    endtask

    task automatic push_wr(input logic [31:0] addr, input logic [255:0] line, input int n);
        cmd_t c;
        for (int k = 0; k < n; k++) begin
            c.rd = 1'b0; c.addr = addr; c.wdata = line[k*64 +: 64];
            cmd_q.push_back(c);
        end
    endtask

    task automatic exp_i(input logic [255:0] line);
        resp_t r;
        r.wr = 1'b0; r.data = line;
        i_q.push_back(r);
    endtask

    task automatic exp_d(input logic wr, input logic [255:0] line);
        resp_t r;
        r.wr = wr; r.data = line;
        d_q.push_back(r);
    endtask

    task automatic monitor();
        cmd_t  c;
        resp_t r;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                if (bmem_read || bmem_write) begin
                    checks++;
                    if (cmd_q.size() == 0) begin
                        errors++;
                        $display("FAIL cmd_unexpected read=%0b write=%0b addr=%h, required no command",
                                 bmem_read, bmem_write, bmem_addr);
                    end else begin
                        c = cmd_q.pop_front();
                        if (bmem_read !== c.rd || bmem_write !== !c.rd || bmem_addr !== c.addr
                            || (!c.rd && bmem_wdata !== c.wdata)) begin
                            errors++;
                            $display("FAIL cmd read=%0b write=%0b addr=%h wdata=%h, required read=%0b write=%0b addr=%h wdata=%h",
                                     bmem_read, bmem_write, bmem_addr, bmem_wdata, c.rd, !c.rd, c.addr, c.wdata);
                        end
                    end
                end else begin
                    checks++;
                    if (bmem_addr !== 32'h0) begin
                        errors++;
                        $display("FAIL idle_addr addr=%h, required 00000000", bmem_addr);
                    end
                end
                if (i_resp) begin
                    checks++;
                    if (i_q.size() == 0) begin
                        errors++;
                        $display("FAIL i_resp_unexpected i_rdata=%h, required no i_resp", i_rdata);
                    end else begin
                        r = i_q.pop_front();
                        if (i_rdata !== r.data || d_rdata !== d_last) begin
                            errors++;
                            $display("FAIL i_resp_data i_rdata=%h d_rdata=%h, required %h %h",
                                     i_rdata, d_rdata, r.data, d_last);
                        end
                        i_last = r.data;
                    end
                end
                if (d_resp) begin
                    checks++;
                    if (d_q.size() == 0) begin
                        errors++;
                        $display("FAIL d_resp_unexpected d_rdata=%h, required no d_resp", d_rdata);
                    end else begin
                        r = d_q.pop_front();
                        if (i_rdata !== i_last || (!r.wr && d_rdata !== r.data)) begin
                            errors++;
                            $display("FAIL d_resp_data d_rdata=%h i_rdata=%h, required %h %h",
                                     d_rdata, i_rdata, r.data, i_last);
                        end
                        if (!r.wr) d_last = r.data;
                    end
                end
            end
        end
    endtask

    // Four ascending beats tagged addr; who: 0 none, 1 icache, 2 dcache expected to respond.
    task automatic send_beats(input logic [31:0] addr, input logic [255:0] line, input int who);
        for (int k = 0; k < 4; k++) begin
            bmem_raddr  = addr;
            bmem_rdata  = line[k*64 +: 64];
            bmem_rvalid = 1'b1;
            tick();
        end
        bmem_rvalid = 1'b0;
        bmem_raddr  = '0;
        bmem_rdata  = '0;
        checks++;
        if (i_resp !== (who == 1) || d_resp !== (who == 2)) begin
            errors++;
            $display("FAIL resp_latency i_resp=%0b d_resp=%0b, required %0b %0b",
                     i_resp, d_resp, who == 1, who == 2);
        end
        if (who == 1) i_read = 1'b0;
        if (who == 2) d_read = 1'b0;
        tick();
        checks++;
        if (i_resp !== 1'b0 || d_resp !== 1'b0) begin
            errors++;
            $display("FAIL resp_width i_resp=%0b d_resp=%0b, required 0 0", i_resp, d_resp);
        end
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while ((cmd_q.size() + i_q.size() + d_q.size()) != 0 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if ((cmd_q.size() + i_q.size() + d_q.size()) != 0) begin
            errors++;
            $display("FAIL %s_drain pending cmd=%0d i=%0d d=%0d, required 0 0 0",
                     tag, cmd_q.size(), i_q.size(), d_q.size());
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
        bmem_rvalid = 1'b0; bmem_raddr = '0; bmem_rdata = '0;
        tick();
        i_last = '0; d_last = '0;
        cmd_q.delete(); i_q.delete(); d_q.delete();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bmem_ready = 1'b1;
        i_addr = 32'h1234_5678; d_addr = 32'h8765_4321;
        i_read = 1'b1; d_read = 1'b1;
        tick(); tick();
        checks++;
        if ({bmem_read, bmem_write, i_resp, d_resp} !== 4'b0 || bmem_addr !== '0 || bmem_wdata !== '0) begin
            errors++;
            $display("FAIL reset_ctrl read=%0b write=%0b i_resp=%0b d_resp=%0b addr=%h wdata=%h, required all 0",
                     bmem_read, bmem_write, i_resp, d_resp, bmem_addr, bmem_wdata);
        end
        checks++;
        if (i_rdata !== '0 || d_rdata !== '0) begin
            errors++;
            $display("FAIL reset_rdata i_rdata=%h d_rdata=%h, required 0 0", i_rdata, d_rdata);
        end
        i_read = 1'b0; d_read = 1'b0;
        i_last = '0; d_last = '0;
        rst = 1'b1;
        tick(); tick();
    endtask

    task automatic test_read();
        logic [255:0] l;
        l = mk_line(32'hA0A0_0000);
        bmem_ready = 1'b0;
        i_addr = 32'h1000_0004; i_read = 1'b1;
        tick(); tick();
        checks++;
        if (bmem_read !== 1'b0) begin
            errors++;
            $display("FAIL read_ready_low read=%0b, required 0", bmem_read);
        end
        push_rd(32'h1000_0000);
        bmem_ready = 1'b1;
        tick();
        checks++;
        if (bmem_read !== 1'b1 || bmem_addr !== 32'h1000_0000) begin
            errors++;
            $display("FAIL read_issue read=%0b addr=%h, required 1 10000000", bmem_read, bmem_addr);
        end
        tick();
        checks++;
        if (bmem_read !== 1'b0 || bmem_addr !== 32'h0) begin
            errors++;
            $display("FAIL read_single_cycle read=%0b addr=%h, required 0 00000000", bmem_read, bmem_addr);
        end
        exp_i(l);
        send_beats(32'h1000_0000, l, 1);
        wait_drain("read");
    endtask

    task automatic test_tie();
        logic [255:0] li, ld;
        do_reset();
        li = mk_line(32'h4444_0000); ld = mk_line(32'h5555_0000);
        push_rd(32'h5000_0040); push_rd(32'h4000_0000);
        i_addr = 32'h4000_0000; d_addr = 32'h5000_0040;
        i_read = 1'b1; d_read = 1'b1;
        tick();
        checks++;
        if (bmem_read !== 1'b1 || bmem_addr !== 32'h5000_0040) begin
            errors++;
            $display("FAIL tie_first read=%0b addr=%h, required 1 50000040", bmem_read, bmem_addr);
        end
        tick();
        checks++;
        if (bmem_read !== 1'b1 || bmem_addr !== 32'h4000_0000) begin
            errors++;
            $display("FAIL tie_second read=%0b addr=%h, required 1 40000000", bmem_read, bmem_addr);
        end
        exp_d(1'b0, ld); send_beats(32'h5000_0040, ld, 2);
        exp_i(li);       send_beats(32'h4000_0000, li, 1);
        // a lone dcache grant makes icache win the next tie
        ld = mk_line(32'h5656_0000);
        push_rd(32'h5000_0080);
        d_addr = 32'h5000_0080; d_read = 1'b1;
        tick(); tick();
        exp_d(1'b0, ld); send_beats(32'h5000_0080, ld, 2);
        li = mk_line(32'h4747_0000); ld = mk_line(32'h5757_0000);
        push_rd(32'h4000_0020); push_rd(32'h5000_00C0);
        i_addr = 32'h4000_0020; d_addr = 32'h5000_00C0;
        i_read = 1'b1; d_read = 1'b1;
        tick();
        checks++;
        if (bmem_read !== 1'b1 || bmem_addr !== 32'h4000_0020) begin
            errors++;
            $display("FAIL rr_first read=%0b addr=%h, required 1 40000020", bmem_read, bmem_addr);
        end
        tick();
        exp_i(li); send_beats(32'h4000_0020, li, 1);
        exp_d(1'b0, ld); send_beats(32'h5000_00C0, ld, 2);
        wait_drain("tie");
    endtask

    task automatic test_write();
        logic [255:0] w, li;
        w  = mk_line(32'hC0DE_0000);
        li = mk_line(32'h6666_0000);
        push_wr(32'h2000_0020, w, 4);
        push_rd(32'h6000_0000);
        exp_d(1'b1, '0);
        d_addr = 32'h2000_0020; d_wdata = w; d_write = 1'b1;
        tick(); tick();
        i_addr = 32'h6000_0000; i_read = 1'b1;
        tick(); tick();
        checks++;
        if (d_resp !== 1'b0 || bmem_write !== 1'b1) begin
            errors++;
            $display("FAIL write_last_beat d_resp=%0b write=%0b, required 0 1", d_resp, bmem_write);
        end
        tick();
        checks++;
        if (d_resp !== 1'b1 || bmem_write !== 1'b0) begin
            errors++;
            $display("FAIL write_resp d_resp=%0b write=%0b, required 1 0", d_resp, bmem_write);
        end
        d_write = 1'b0;
        tick(); tick();
        exp_i(li); send_beats(32'h6000_0000, li, 1);
        wait_drain("write");
    endtask

    task automatic test_out_of_order();
        logic [255:0] li, ld;
        li = mk_line(32'h7070_0000); ld = mk_line(32'h7171_0000);
        push_rd(32'h7100_0000);
        d_addr = 32'h7100_0000; d_read = 1'b1;
        tick();
        // icache issues in the same cycle the first dcache beat is accepted
        push_rd(32'h7000_0000);
        i_addr = 32'h7000_0000; i_read = 1'b1;
        exp_d(1'b0, ld); send_beats(32'h7100_0000, ld, 2);
        exp_i(li);       send_beats(32'h7000_0000, li, 1);
        wait_drain("ooo");
    endtask

    task automatic test_drop_alias();
        logic [255:0] j, li, ld;
        j = mk_line(32'hDEAD_0000);
        send_beats(32'h3000_0000, j, 0);
        checks++;
        if (i_rdata !== i_last || d_rdata !== d_last) begin
            errors++;
            $display("FAIL drop_state i_rdata=%h d_rdata=%h, required %h %h", i_rdata, d_rdata, i_last, d_last);
        end
        li = mk_line(32'h3131_0000); ld = mk_line(32'h3232_0000);
        push_rd(32'h3000_0040);
        i_addr = 32'h3000_0044; i_read = 1'b1;
        tick(); tick();
        d_addr = 32'h3000_0048; d_read = 1'b1;
        tick(); tick(); tick();
        exp_i(li); send_beats(32'h3000_0040, li, 1);
        push_rd(32'h3000_0040);
        checks++;
        if (bmem_read !== 1'b1 || bmem_addr !== 32'h3000_0040) begin
            errors++;
            $display("FAIL alias_issue read=%0b addr=%h, required 1 30000040", bmem_read, bmem_addr);
        end
        tick();
        exp_d(1'b0, ld); send_beats(32'h3000_0040, ld, 2);
        wait_drain("alias");
    endtask

    task automatic test_reset_mid_write();
        logic [255:0] w, ld;
        w  = mk_line(32'hBEEF_0000);
        ld = mk_line(32'h2222_0000);
        push_wr(32'h2000_0020, w, 2);
        d_addr = 32'h2000_0020; d_wdata = w; d_write = 1'b1;
        tick(); tick(); tick();
        checks++;
        if (bmem_write !== 1'b1 || bmem_wdata !== w[128 +: 64]) begin
            errors++;
            $display("FAIL mid_write write=%0b wdata=%h, required 1 %h", bmem_write, bmem_wdata, w[128 +: 64]);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({bmem_read, bmem_write, i_resp, d_resp} !== 4'b0 || bmem_addr !== '0 || bmem_wdata !== '0
            || i_rdata !== '0 || d_rdata !== '0) begin
            errors++;
            $display("FAIL async_reset read=%0b write=%0b resp=%0b%0b addr=%h wdata=%h, required all 0",
                     bmem_read, bmem_write, i_resp, d_resp, bmem_addr, bmem_wdata);
        end
        d_write = 1'b0;
        tick();
        i_last = '0; d_last = '0;
        rst = 1'b1;
        tick();
        send_beats(32'h2000_0020, w, 0);
        push_rd(32'h2000_0020);
        d_read = 1'b1;
        tick();
        checks++;
        if (bmem_read !== 1'b1 || bmem_addr !== 32'h2000_0020) begin
            errors++;
            $display("FAIL post_reset_issue read=%0b addr=%h, required 1 20000020", bmem_read, bmem_addr);
        end
        tick();
        exp_d(1'b0, ld); send_beats(32'h2000_0020, ld, 2);
        wait_drain("reset_write");
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b0;
        i_addr = '0; i_read = 1'b0;
        d_addr = '0; d_read = 1'b0; d_write = 1'b0; d_wdata = '0;
        bmem_ready = 1'b1; bmem_raddr = '0; bmem_rdata = '0; bmem_rvalid = 1'b0;
        i_last = '0; d_last = '0;
        fork
            monitor();
        join_none
        test_reset();
        test_read();
        test_tie();
        test_write();
        test_out_of_order();
        test_drop_alias();
        test_reset_mid_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_sched.md
MEM_SCHED -- requirements
Module: mem_sched

Interface
REQ-001 SHALL have parameter BURST_LEN, default 4: 64-bit beats per 256-bit line.
REQ-002 SHALL have parameter LINE_W, default 256: requester line width in bits.
REQ-003 SHALL have one clock and an asynchronous, active-low reset:
- clk  in  1  sole clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have these icache ports:
- i_addr  in  32  icache line address.
- i_read  in  1  icache read request, held until i_resp.
- i_rdata  out  256  icache line data.
- i_resp  out  1  icache completion pulse.
REQ-005 SHALL have these dcache ports:
- d_addr  in  32  dcache line address.
- d_read  in  1  dcache read request, held until d_resp.
- d_write  in  1  dcache writeback request, held until d_resp.
- d_wdata  in  256  dcache writeback line.
- d_rdata  out  256  dcache line data.
- d_resp  out  1  dcache completion pulse.
REQ-006 SHALL have these memory ports:
- bmem_addr  out  32  command address.
- bmem_read  out  1  read command.
- bmem_write  out  1  write beat valid.
- bmem_wdata  out  64  write beat.
- bmem_ready  in  1  memory accepts a command.
- bmem_raddr  in  32  address tag of the returning read.
- bmem_rdata  in  64  read beat.
- bmem_rvalid  in  1  read beat valid.

Function
REQ-007 SHALL force bmem_addr[4:0]=0 on every command.
REQ-008 SHALL keep, per requester, an outstanding flag set at command issue and cleared on resp.
REQ-009 SHALL run states IDLE and WRITE; WRITE uses a 2-bit beat counter.
REQ-010 SHALL make a requester eligible in IDLE when its request is high, it has no outstanding flag, and bmem_ready=1.
REQ-011 SHALL grant one eligible requester per cycle, round-robin; last-grant register resets to icache, so dcache wins the first tie.
REQ-012 SHALL issue a read as a single cycle with bmem_read=1 and bmem_addr=line.
REQ-013 SHALL issue a dcache write only when no dcache read is outstanding.
REQ-014 SHALL drive write beats with bmem_write=1 for BURST_LEN consecutive cycles, same address, beat k = d_wdata[64k+63:64k], k=0 first.
REQ-015 SHALL make no grant while in WRITE.
REQ-016 SHALL pulse d_resp one cycle after the last write beat, then return to IDLE.
REQ-017 SHALL allow both reads outstanding at once; returns may arrive in either order, each burst's beats contiguous and ascending.
REQ-018 SHALL route each rvalid beat to the requester whose outstanding read line equals bmem_raddr[31:5]; a beat matching none SHALL be dropped.
REQ-019 SHALL hold an icache read whose line equals an outstanding dcache read line (and vice versa) until that read completes.
REQ-020 SHALL assemble beats into a per-requester 256-bit buffer.
REQ-021 SHALL pulse resp for exactly one cycle, the cycle after the 4th beat, with rdata valid.
REQ-022 SHALL hold rdata stable until the next resp of that requester.
REQ-023 SHALL allow a new command issue and an rvalid beat in the same cycle, with both processed.
REQ-024 SHALL drive bmem_read, bmem_write and bmem_addr to 0 when no command is issued.
REQ-025 SHALL allow at most one of bmem_read and bmem_write high per cycle.

Reset
REQ-026 SHALL, while rst=0, drive all outputs to 0 and clear state to IDLE, beat counter 0, outstanding flags 0, buffers 0, last-grant=icache.
REQ-027 SHALL abort any in-flight burst or read on rst asserted mid-operation, with no resp.
REQ-028 SHALL drop beats returning after reset release via REQ-018.

Verification
REQ-029 SHALL pass: i_read, addr 0x1000_0004, ready=1 -> bmem_read one cycle at 0x1000_0000; 4 beats A..D tagged 0x1000_0000 -> i_resp next cycle, i_rdata={D,C,B,A}.
REQ-030 SHALL pass: i_read and d_read same cycle after reset -> dcache command first, icache next eligible cycle.
REQ-031 SHALL pass: d_write 0x2000_0020, d_wdata words W0..W7 -> 4 write beats {W1,W0}..{W7,W6}; d_resp one cycle after last beat; i_read during burst waits.
REQ-032 SHALL pass: both reads outstanding, dcache data returned first -> each resp carries own data; i_rdata unchanged at d_resp.
REQ-033 SHALL pass: rvalid tagged 0x3000_0000 with nothing outstanding -> no resp, no state change; equal i/d line -> second read issued after first resp.
REQ-034 SHALL pass: rst low at beat 2 of a write -> outputs 0 asynchronously; after release, IDLE with flags clear.
